// File: rtl/carry_resolve_unit.sv
`default_nettype none
// ============================================================================
// carry_resolve_unit : iterative add/subtract that resolves carries by XOR/AND
//                      recirculation, with valid/ready handshakes on both sides.
// Optional feature macro: CRU_LT_FLAG_EN (adds out_lt, unsigned a < b on sub).
// Revision: 1.0
// ============================================================================
module carry_resolve_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
`ifdef CRU_LT_FLAG_EN
  output logic             out_lt,
`endif
  output logic [5:0]       out_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             op;
  logic             cflag;
  logic [5:0]       count;
  logic [WIDTH-1:0] gen;
  logic             y_zero;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign y_zero    = (y == '0);
  // Subtract generates a borrow where x is 0 and y is 1; add where both are 1.
  assign gen       = op ? (~x & y) : (x & y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ITER;
      ITER:    if (y_zero) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      op         <= 1'b0;
      cflag      <= 1'b0;
      count      <= 6'd0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_cycles <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= in_a;
            y     <= in_b;
            op    <= in_op;
            cflag <= 1'b0;
            count <= 6'd0;
          end
        end
        ITER: begin
          if (!y_zero) begin
            x     <= x ^ y;
            // The bit leaving the top of y is recorded only through cflag.
            y     <= {gen[WIDTH-2:0], 1'b0};
            cflag <= cflag | gen[WIDTH-1];
            count <= count + 6'd1;
          end else begin
            out_result <= x;
            out_carry  <= cflag;
            out_zero   <= (x == '0);
            out_cycles <= count;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CRU_LT_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_lt <= 1'b0;
    end else if (state == ITER && y_zero) begin
      out_lt <= op & cflag;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_carry_resolve_unit.sv
`default_nettype none
// Directed self-checking bench for carry_resolve_unit (WIDTH = 32).
module tb_carry_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic [5:0]  out_cycles;
`ifdef CRU_LT_FLAG_EN
  logic        out_lt;
`endif

  int total = 0;
  int bad   = 0;

  carry_resolve_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
`ifdef CRU_LT_FLAG_EN
    .out_lt     (out_lt),
`endif
    .out_cycles (out_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge in IDLE, scramble inputs while busy, check result.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic ez,
                        input int ecyc, input logic elt, input bit pop);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_op = ~op; in_a = $urandom; in_b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_result"}, out_result, er);
    check({tag, "_carry"}, out_carry, ec);
    check({tag, "_zero"}, out_zero, ez);
    check({tag, "_inready"}, in_ready, 1'b0);
    if (ecyc >= 0) begin
      check({tag, "_cycles"}, out_cycles, ecyc);
      check({tag, "_latency"}, lat, ecyc + 1);
    end
`ifdef CRU_LT_FLAG_EN
    check({tag, "_lt"}, out_lt, elt);
`else
    if (elt !== 1'bx) begin end
`endif
    if (pop) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_popped"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {out_valid, out_result, out_carry, out_zero, out_cycles}, '0);
    check("rst_inready", in_ready, 1'b1);
    // Requests presented during reset must be ignored.
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd4;
    repeat (3) @(negedge clk);
    check("rst_noaccept", {in_ready, out_valid}, 2'b10);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {in_ready, out_valid}, 2'b10);

    run_op("add5p3", 1'b0, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 4, 1'b0, 1'b1);
    run_op("add0p0", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    run_op("sub10m3", 1'b1, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 4, 1'b0, 1'b1);
    run_op("addmax", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 32, 1'b0, 1'b1);
    run_op("sub3m5", 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 30, 1'b1, 1'b1);

    // Stall in DONE while inputs churn; outputs must not move.
    run_op("stall", 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom_range(0, 1)); in_op = 1'($urandom_range(0, 1));
      in_a = $urandom; in_b = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("stall_hold", {out_valid, in_ready, out_result, out_carry, out_zero},
            {1'b1, 1'b0, 32'h2143_6587, 1'b0, 1'b0});
    end
    in_valid = 1'b1; in_op = 1'b0; in_b = 32'd0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_pop_noaccept", {out_valid, in_ready}, 2'b01);
    in_valid = 1'b0; out_ready = 1'b0;

    // Back-to-back zero-operand adds with out_ready tied high: one result per 3 cycles.
    out_ready = 1'b1; in_valid = 1'b1; in_op = 1'b0; in_a = 32'hA5A5_0000; in_b = 32'd0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k % 3 == 2) begin
        check("b2b_valid", out_valid, 1'b1);
        check("b2b_res", {out_result, out_carry, out_zero, out_cycles}, {32'hA5A5_0000, 1'b0, 1'b0, 6'd0});
      end else begin
        check("b2b_gap", out_valid, 1'b0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset mid-ITER aborts without a result.
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 32'hFFFF_FFFF; in_b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun_busy", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_async", {out_valid, in_ready, out_result}, {1'b1 ^ 1'b1, 1'b1, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_nostale", {out_valid, in_ready}, 2'b01);
    run_op("sub7m7", 1'b1, 32'd7, 32'd7, 32'd0, 1'b0, 1'b1, 1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
